// File: rtl/gates_pkg.sv
// rtl/gates_pkg.sv - shared constants for the basic-gates library
package gates_pkg;

    localparam int   GATES_DEFAULT_WIDTH = 1;
    // Registers clear to all-zero; out_valid=0 marks the contents as meaningless.
    localparam logic GATES_RESET_BIT     = 1'b0;

endpackage : gates_pkg

// File: rtl/gate_reg.sv
// rtl/gate_reg.sv - WIDTH-bit register with async active-low clear and load enable
module gate_reg
    import gates_pkg::*;
#(
    parameter int WIDTH = GATES_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= {WIDTH{GATES_RESET_BIT}};
        end else if (en) begin
            q <= d;
        end
    end

endmodule : gate_reg

// File: rtl/and_nand_nor_unit.sv
// rtl/and_nand_nor_unit.sv - bitwise AND/NAND/NOR with combinational and registered outputs
module and_nand_nor_unit
    import gates_pkg::*;
#(
    parameter int WIDTH = GATES_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_y,
    output logic [WIDTH-1:0] nand_y,
    output logic [WIDTH-1:0] nor_y,
    output logic [WIDTH-1:0] and_q,
    output logic [WIDTH-1:0] nand_q,
    output logic [WIDTH-1:0] nor_q,
    output logic             out_valid
);

    assign and_y  = a & b;
    assign nand_y = ~(a & b);
    assign nor_y  = ~(a | b);

    gate_reg #(.WIDTH(WIDTH)) u_and_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .d     (and_y),
        .q     (and_q)
    );

    gate_reg #(.WIDTH(WIDTH)) u_nand_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .d     (nand_y),
        .q     (nand_q)
    );

    gate_reg #(.WIDTH(WIDTH)) u_nor_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (in_valid),
        .d     (nor_y),
        .q     (nor_q)
    );

    // out_valid follows in_valid every cycle, so the results hold while it drops.
    gate_reg #(.WIDTH(1)) u_valid_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .d     (in_valid),
        .q     (out_valid)
    );

endmodule : and_nand_nor_unit

// File: tb/tb_and_nand_nor_unit.sv
// tb/tb_and_nand_nor_unit.sv - scoreboard bench for and_nand_nor_unit at WIDTH 1 and 8
module tb_and_nand_nor_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       a1, b1;
    logic [7:0] a8, b8;

    logic       and_y1, nand_y1, nor_y1, and_q1, nand_q1, nor_q1, out_valid1;
    logic [7:0] and_y8, nand_y8, nor_y8, and_q8, nand_q8, nor_q8;
    logic       out_valid8;

    and_nand_nor_unit #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
        .and_y(and_y1), .nand_y(nand_y1), .nor_y(nor_y1),
        .and_q(and_q1), .nand_q(nand_q1), .nor_q(nor_q1), .out_valid(out_valid1)
    );

    and_nand_nor_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
        .and_y(and_y8), .nand_y(nand_y8), .nor_y(nor_y8),
        .and_q(and_q8), .nand_q(nand_q8), .nor_q(nor_q8), .out_valid(out_valid8)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] and8, nand8, nor8;
        logic       and1, nand1, nor1;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: per-bit truth-table lookup indexed by {a,b}.
    function automatic logic [7:0] ref_gate(input int op, input logic [7:0] a, input logic [7:0] b);
        logic [3:0] tt;
        logic [7:0] r;
        case (op)
            0:       tt = 4'b1000;
            1:       tt = 4'b0111;
            default: tt = 4'b0001;
        endcase
        for (int i = 0; i < 8; i++) r[i] = tt[{a[i], b[i]}];
        return r;
    endfunction

    function automatic exp_t model(input logic x1, input logic y1, input logic [7:0] x8, input logic [7:0] y8);
        exp_t e;
        logic [7:0] t;
        e.and8  = ref_gate(0, x8, y8);
        e.nand8 = ref_gate(1, x8, y8);
        e.nor8  = ref_gate(2, x8, y8);
        t = ref_gate(0, {7'd0, x1}, {7'd0, y1}); e.and1  = t[0];
        t = ref_gate(1, {7'd0, x1}, {7'd0, y1}); e.nand1 = t[0];
        t = ref_gate(2, {7'd0, x1}, {7'd0, y1}); e.nor1  = t[0];
        return e;
    endfunction

    task automatic check_comb();
        exp_t e;
        e = model(a1, b1, a8, b8);
        check("and_y1",  {7'd0, and_y1},  {7'd0, e.and1});
        check("nand_y1", {7'd0, nand_y1}, {7'd0, e.nand1});
        check("nor_y1",  {7'd0, nor_y1},  {7'd0, e.nor1});
        check("and_y8",  and_y8,  e.and8);
        check("nand_y8", nand_y8, e.nand8);
        check("nor_y8",  nor_y8,  e.nor8);
    endtask

    task automatic check_regs(input string tag, input exp_t e, input logic v);
        check({tag, "_and_q1"},  {7'd0, and_q1},  {7'd0, e.and1});
        check({tag, "_nand_q1"}, {7'd0, nand_q1}, {7'd0, e.nand1});
        check({tag, "_nor_q1"},  {7'd0, nor_q1},  {7'd0, e.nor1});
        check({tag, "_and_q8"},  and_q8,  e.and8);
        check({tag, "_nand_q8"}, nand_q8, e.nand8);
        check({tag, "_nor_q8"},  nor_q8,  e.nor8);
        check({tag, "_valid1"},  {7'd0, out_valid1}, {7'd0, v});
        check({tag, "_valid8"},  {7'd0, out_valid8}, {7'd0, v});
    endtask

    // Called at posedge+2; drives inputs, checks comb paths, returns at next posedge+2.
    task automatic apply(input logic iv, input logic x1, input logic y1, input logic [7:0] x8, input logic [7:0] y8);
        exp_t e;
        in_valid = iv; a1 = x1; b1 = y1; a8 = x8; b8 = y8;
        #1;
        check_comb();
        e = model(x1, y1, x8, y8);
        if (iv && rst_n) begin
            sb_q.push_back(e);
            held = e;
        end
        @(posedge clk); #2;
    endtask

    // Monitor: every negedge with out_valid high corresponds to exactly one capture.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid8 === 1'b1 || out_valid1 === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", 8'd1, 8'd0);
            end else begin
                e = sb_q.pop_front();
                check_regs("sb", e, 1'b1);
            end
        end
    end

    exp_t zero_e;

    initial begin
        zero_e = '{and8: 8'h00, nand8: 8'h00, nor8: 8'h00, and1: 1'b0, nand1: 1'b0, nor1: 1'b0};
        held = zero_e;
        rst_n = 1'b0; in_valid = 1'b0; a1 = 1'b0; b1 = 1'b0; a8 = 8'h00; b8 = 8'h00;
        #1;
        check_regs("reset", zero_e, 1'b0);
        repeat (2) @(posedge clk);
        #2;

        // Release reset together with in_valid=1, a=1, b=0.
        rst_n = 1'b1;
        apply(1'b1, 1'b1, 1'b0, 8'h55, 8'h0F);
        check("rel_and_q1",  {7'd0, and_q1},  8'd0);
        check("rel_nand_q1", {7'd0, nand_q1}, 8'd1);
        check("rel_nor_q1",  {7'd0, nor_q1},  8'd0);
        check("rel_valid",   {7'd0, out_valid1}, 8'd1);

        // Truth-table sweep.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] ab;
            ab = i[1:0];
            apply(1'b0, ab[1], ab[0], {8{ab[1]}}, {8{ab[0]}});
        end

        // Wide vector and 1,1 capture.
        apply(1'b1, 1'b1, 1'b1, 8'hF0, 8'hCC);
        check("wide_and_q8",  and_q8,  8'hC0);
        check("wide_nand_q8", nand_q8, 8'h3F);
        check("wide_nor_q8",  nor_q8,  8'h03);
        check("cap_and_q1",   {7'd0, and_q1}, 8'd1);

        // Hold: capture 0,0 then three idle cycles with toggling inputs.
        apply(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
            check_regs("hold", held, 1'b0);
        end

        // Random mix of captures and idles, including back-to-back.
        for (int i = 0; i < 40; i++) begin
            apply(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom));
            if (in_valid === 1'b0) check_regs("idle", held, 1'b0);
        end

        // Async reset between edges while out_valid=1.
        apply(1'b1, 1'b1, 1'b1, 8'hA5, 8'h3C);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        sb_q.delete();
        held = zero_e;
        #1;
        check_regs("async_rst", zero_e, 1'b0);
        a1 = 1'b1; b1 = 1'b0; a8 = 8'h96; b8 = 8'h69;
        #1;
        check_comb();

        // Reset wins over in_valid.
        in_valid = 1'b1;
        @(posedge clk); #2;
        check_regs("rst_wins", zero_e, 1'b0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #2;

        for (int i = 0; i < 20; i++) begin
            apply(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));
        end
        apply(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(posedge clk); #2;
        check("sb_drained", 8'(sb_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_and_nand_nor_unit
